// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for serial_subtractor.
// SERIAL_SUB_OVF_EN adds the two's-complement overflow flag ovf.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b,
`ifdef SERIAL_SUB_OVF_EN
    input  ovf,
`endif
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b,
`ifdef SERIAL_SUB_OVF_EN
    output ovf,
`endif
    output busy, done, diff, bout
  );

endinterface

// File: rtl/serial_subtractor_full_sub.sv
// Single-bit full subtractor cell: D = A - B - Bin, Bout = borrow out.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// SERIAL_SUB_OVF_EN enables the registered ovf output.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
)(
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned     CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_busy;
  logic             w_done;
  logic             w_last;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-2:0] r_diff_sh;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_diff_nxt;

  full_subtractor u_fs (
    .A    (r_a_sh[0]),
    .B    (r_b_sh[0]),
    .Bin  (r_borrow),
    .D    (w_d),
    .Bout (w_bout)
  );

  // The newest bit enters at the MSB, so after WIDTH shifts bit 0 is the LSB.
  assign w_diff_nxt = {w_d, r_diff_sh};
  assign w_last     = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) w_state_nxt = RUN;
      end
      RUN: begin
        w_busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_diff_sh <= '0;
      r_diff    <= '0;
      r_bout    <= 1'b0;
      r_borrow  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (r_state == IDLE && bus.start) begin
        r_a_sh   <= bus.a;
        r_b_sh   <= bus.b;
        r_borrow <= 1'b0;
        r_cnt    <= '0;
      end else if (r_state == RUN) begin
        r_a_sh    <= r_a_sh >> 1;
        r_b_sh    <= r_b_sh >> 1;
        r_diff_sh <= w_diff_nxt[WIDTH-1:1];
        r_borrow  <= w_bout;
        r_cnt     <= r_cnt + CW'(1);
        if (w_last) begin
          r_diff <= w_diff_nxt;
          r_bout <= w_bout;
        end
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_ovf;

  // On the final RUN edge the shift registers present the operand MSBs at bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == RUN && w_last) begin
      r_ovf <= (r_a_sh[0] != r_b_sh[0]) && (w_d != r_a_sh[0]);
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;

endmodule
